// File: rtl/vending_core_param_if.sv
// Signal bundle between the coin/keypad front end, the vending core and the
// dispenser / change-hopper drivers.
interface vending_core_param_if #(
  parameter int NUM_ITEMS = 4,
  parameter int BAL_W     = 8
);
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic                       coin_valid;
  logic [1:0]                 coin_type;
  logic                       sel_valid;
  logic [IDX_W-1:0]           sel_idx;
  logic                       cancel;
  logic                       restock;
  logic [IDX_W-1:0]           restock_idx;
  logic [NUM_ITEMS*BAL_W-1:0] price_flat;

  logic                       dispense;
  logic [IDX_W-1:0]           dispense_idx;
  logic                       change_valid;
  logic [1:0]                 change_coin;
  logic                       coin_reject;
  logic                       err_funds;
  logic                       err_soldout;
  logic [BAL_W-1:0]           balance;
  logic [NUM_ITEMS-1:0]       sold_out;
  logic                       busy;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_idx, cancel,
           restock, restock_idx, price_flat,
    input  dispense, dispense_idx, change_valid, change_coin, coin_reject,
           err_funds, err_soldout, balance, sold_out, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_idx, cancel,
           restock, restock_idx, price_flat,
    output dispense, dispense_idx, change_valid, change_coin, coin_reject,
           err_funds, err_soldout, balance, sold_out, busy
  );
endinterface

// File: rtl/vending_core_param.sv
// Parametrised multi-item vending controller: credit, per-item stock, vend and
// greedy one-coin-per-cycle change return. All outputs are registered.
module vending_core_param #(
  parameter int NUM_ITEMS  = 4,
  parameter int BAL_W      = 8,
  parameter int MAX_BAL    = 200,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  vending_core_param_if.slave bus
);
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VEND   = 2'd1;
  localparam logic [1:0] ST_CHANGE = 2'd2;

  localparam logic [BAL_W-1:0]     V5           = BAL_W'(5);
  localparam logic [BAL_W-1:0]     V10          = BAL_W'(10);
  localparam logic [BAL_W-1:0]     V25          = BAL_W'(25);
  localparam logic [BAL_W:0]       MAX_BAL_EXT  = (BAL_W+1)'(MAX_BAL);
  localparam logic [STOCK_W-1:0]   INIT_STOCK_V = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0]   STOCK_ONE    = STOCK_W'(1);
  localparam logic [NUM_ITEMS-1:0] SOLD_OUT_RST = {NUM_ITEMS{INIT_STOCK == 0}};

  logic [1:0]           state_q, state_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [IDX_W-1:0]     vend_idx_q, vend_idx_d;
  logic [BAL_W-1:0]     vend_price_q, vend_price_d;
  logic                 dispense_q, dispense_d;
  logic [IDX_W-1:0]     dispense_idx_q, dispense_idx_d;
  logic                 change_valid_q, change_valid_d;
  logic [1:0]           change_coin_q, change_coin_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 err_funds_q, err_funds_d;
  logic                 err_soldout_q, err_soldout_d;
  logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

  logic                 sel_in_range;
  logic [STOCK_W-1:0]   sel_stock;
  logic [BAL_W-1:0]     sel_price;
  logic                 coin_legal;
  logic [BAL_W-1:0]     coin_val;
  logic [BAL_W:0]       coin_sum;
  logic                 coin_fits;

  // Look up stock and price of the selected item without indexing past the table.
  always_comb begin
    sel_in_range = 1'b0;
    sel_stock    = '0;
    sel_price    = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel_idx == IDX_W'(i)) begin
        sel_in_range = 1'b1;
        sel_stock    = stock_q[i];
        sel_price    = bus.price_flat[i*BAL_W +: BAL_W];
      end
    end
  end

  always_comb begin
    coin_legal = 1'b1;
    coin_val   = '0;
    case (bus.coin_type)
      2'b00:   coin_val = V5;
      2'b01:   coin_val = V10;
      2'b10:   coin_val = V25;
      default: coin_legal = 1'b0;
    endcase
  end

  // One extra bit so the ceiling test cannot wrap when MAX_BAL is near 2^BAL_W.
  assign coin_sum  = {1'b0, balance_q} + {1'b0, coin_val};
  assign coin_fits = coin_legal && (coin_sum <= MAX_BAL_EXT);

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    stock_d        = stock_q;
    vend_idx_d     = vend_idx_q;
    vend_price_d   = vend_price_q;
    dispense_d     = 1'b0;
    dispense_idx_d = dispense_idx_q;
    change_valid_d = 1'b0;
    change_coin_d  = change_coin_q;
    coin_reject_d  = 1'b0;
    err_funds_d    = 1'b0;
    err_soldout_d  = 1'b0;
    sold_out_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cancel) begin
          coin_reject_d = bus.coin_valid;
          if (balance_q != '0) state_d = ST_CHANGE;
        end else if (bus.sel_valid) begin
          coin_reject_d = bus.coin_valid;
          if (!sel_in_range || (sel_stock == '0)) begin
            err_soldout_d = 1'b1;
          end else if (balance_q < sel_price) begin
            err_funds_d = 1'b1;
          end else begin
            state_d      = ST_VEND;
            vend_idx_d   = bus.sel_idx;
            vend_price_d = sel_price;
          end
        end else if (bus.coin_valid) begin
          if (coin_fits) balance_d = coin_sum[BAL_W-1:0];
          else           coin_reject_d = 1'b1;
        end
      end

      ST_VEND: begin
        coin_reject_d  = bus.coin_valid;
        dispense_d     = 1'b1;
        dispense_idx_d = vend_idx_q;
        balance_d      = balance_q - vend_price_q;
        for (int i = 0; i < NUM_ITEMS; i++) begin
          if (vend_idx_q == IDX_W'(i)) stock_d[i] = stock_q[i] - STOCK_ONE;
        end
        state_d = (balance_d != '0) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        coin_reject_d  = bus.coin_valid;
        change_valid_d = 1'b1;
        if (balance_q >= V25) begin
          change_coin_d = 2'b10;
          balance_d     = balance_q - V25;
        end else if (balance_q >= V10) begin
          change_coin_d = 2'b01;
          balance_d     = balance_q - V10;
        end else if (balance_q >= V5) begin
          change_coin_d = 2'b00;
          balance_d     = balance_q - V5;
        end else begin
          change_valid_d = 1'b0;
          balance_d      = '0;
        end
        if (balance_d == '0) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Restock is applied last so it overrides a same-cycle vend decrement.
    if (bus.restock) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (bus.restock_idx == IDX_W'(i)) stock_d[i] = INIT_STOCK_V;
      end
    end

    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out_d[i] = (stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      balance_q      <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= INIT_STOCK_V;
      vend_idx_q     <= '0;
      vend_price_q   <= '0;
      dispense_q     <= 1'b0;
      dispense_idx_q <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'b00;
      coin_reject_q  <= 1'b0;
      err_funds_q    <= 1'b0;
      err_soldout_q  <= 1'b0;
      sold_out_q     <= SOLD_OUT_RST;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
      vend_idx_q     <= vend_idx_d;
      vend_price_q   <= vend_price_d;
      dispense_q     <= dispense_d;
      dispense_idx_q <= dispense_idx_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      err_funds_q    <= err_funds_d;
      err_soldout_q  <= err_soldout_d;
      sold_out_q     <= sold_out_d;
    end
  end

  assign bus.dispense     = dispense_q;
  assign bus.dispense_idx = dispense_idx_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.err_funds    = err_funds_q;
  assign bus.err_soldout  = err_soldout_q;
  assign bus.balance      = balance_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vending_core_param.sv
// Scoreboard bench for vending_core_param: expected pulse snapshots are queued
// as stimulus is issued and a monitor pops one whenever the DUT pulses.
module tb_vending_core_param;
  localparam int NUM_ITEMS = 4;
  localparam int BAL_W     = 8;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic       dispense;
    logic [1:0] dispense_idx;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic       err_funds;
    logic       err_soldout;
  } ev_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];

  vending_core_param_if #(.NUM_ITEMS(NUM_ITEMS), .BAL_W(BAL_W)) bus_if ();

  vending_core_param #(
    .NUM_ITEMS (NUM_ITEMS),
    .BAL_W     (BAL_W),
    .MAX_BAL   (200),
    .STOCK_W   (4),
    .INIT_STOCK(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ev_t ev_none();
    ev_t e;
    e = '0;
    return e;
  endfunction

  function automatic ev_t ev_dispense(input logic [1:0] idx);
    ev_t e;
    e = '0;
    e.dispense     = 1'b1;
    e.dispense_idx = idx;
    return e;
  endfunction

  function automatic ev_t ev_change(input logic [1:0] coin);
    ev_t e;
    e = '0;
    e.change_valid = 1'b1;
    e.change_coin  = coin;
    return e;
  endfunction

  function automatic ev_t ev_reject(input ev_t base);
    ev_t e;
    e = base;
    e.coin_reject = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_funds();
    ev_t e;
    e = '0;
    e.err_funds = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_soldout();
    ev_t e;
    e = '0;
    e.err_soldout = 1'b1;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: any pulse on the DUT outputs consumes one queued expectation.
  initial begin
    ev_t act;
    ev_t req;
    forever begin
      @(negedge clk);
      act              = '0;
      act.dispense     = bus_if.dispense;
      act.dispense_idx = bus_if.dispense ? bus_if.dispense_idx : 2'b00;
      act.change_valid = bus_if.change_valid;
      act.change_coin  = bus_if.change_valid ? bus_if.change_coin : 2'b00;
      act.coin_reject  = bus_if.coin_reject;
      act.err_funds    = bus_if.err_funds;
      act.err_soldout  = bus_if.err_soldout;
      if (act != ev_none()) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_pulse actual=%b required=none", act);
        end else begin
          req = exp_q.pop_front();
          if (act !== req) begin
            bad++;
            $display("[TB] FAIL pulse_event actual=%b required=%b", act, req);
          end
        end
      end
    end
  end

  // Called at a falling edge; holds the strobes for exactly one rising edge.
  task automatic apply_stimulus(input logic cv, input logic [1:0] ct,
                                input logic sv, input logic [IDX_W-1:0] si,
                                input logic cn, input logic rs,
                                input logic [IDX_W-1:0] ri);
    bus_if.coin_valid  = cv;
    bus_if.coin_type   = ct;
    bus_if.sel_valid   = sv;
    bus_if.sel_idx     = si;
    bus_if.cancel      = cn;
    bus_if.restock     = rs;
    bus_if.restock_idx = ri;
    @(negedge clk);
    bus_if.coin_valid  = 1'b0;
    bus_if.sel_valid   = 1'b0;
    bus_if.cancel      = 1'b0;
    bus_if.restock     = 1'b0;
  endtask

  task automatic insert_coin(input logic [1:0] ct);
    apply_stimulus(1'b1, ct, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic select_item(input logic [IDX_W-1:0] idx);
    apply_stimulus(1'b0, 2'b00, 1'b1, idx, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus_if.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus_if.busy) begin
      bad++;
      $display("[TB] FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus_if.coin_valid  = 1'b0;
    bus_if.coin_type   = 2'b00;
    bus_if.sel_valid   = 1'b0;
    bus_if.sel_idx     = '0;
    bus_if.cancel      = 1'b0;
    bus_if.restock     = 1'b0;
    bus_if.restock_idx = '0;
    bus_if.price_flat  = {8'd40, 8'd25, 8'd15, 8'd10};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_output("rst_balance", 32'(bus_if.balance), 0);
    check_output("rst_busy", 32'(bus_if.busy), 0);
    check_output("rst_sold_out", 32'(bus_if.sold_out), 0);
    check_output("rst_dispense_idx", 32'(bus_if.dispense_idx), 0);
    check_output("rst_change_coin", 32'(bus_if.change_coin), 0);

    // Vend item 1 (15) from 50: dispense then change 25 and 10.
    insert_coin(2'b10);
    check_output("bal_after_25", 32'(bus_if.balance), 25);
    insert_coin(2'b10);
    check_output("bal_after_50", 32'(bus_if.balance), 50);
    exp_q.push_back(ev_dispense(2'd1));
    exp_q.push_back(ev_change(2'b10));
    exp_q.push_back(ev_change(2'b01));
    select_item(2'd1);
    check_output("busy_after_select", 32'(bus_if.busy), 1);
    wait_idle("vend_change");
    check_output("bal_after_vend_change", 32'(bus_if.balance), 0);

    // Exact payment: busy drops together with the dispense pulse.
    insert_coin(2'b01);
    exp_q.push_back(ev_dispense(2'd0));
    select_item(2'd0);
    check_output("exact_busy_vend", 32'(bus_if.busy), 1);
    idle_cycle();
    check_output("exact_dispense_seen", 32'(bus_if.dispense), 1);
    check_output("exact_busy_done", 32'(bus_if.busy), 0);
    check_output("exact_balance", 32'(bus_if.balance), 0);

    // Fill to the 200 ceiling, then overflow and invalid coins are rejected.
    for (int i = 0; i < 8; i++) insert_coin(2'b10);
    check_output("bal_full", 32'(bus_if.balance), 200);
    exp_q.push_back(ev_reject(ev_none()));
    insert_coin(2'b10);
    check_output("bal_after_overflow", 32'(bus_if.balance), 200);
    exp_q.push_back(ev_reject(ev_none()));
    insert_coin(2'b11);
    check_output("bal_after_invalid", 32'(bus_if.balance), 200);

    // Cancel returns eight 25s; a coin during the first change cycle is rejected.
    exp_q.push_back(ev_reject(ev_change(2'b10)));
    for (int i = 0; i < 7; i++) exp_q.push_back(ev_change(2'b10));
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    insert_coin(2'b00);
    wait_idle("refund_200");
    check_output("bal_after_refund", 32'(bus_if.balance), 0);

    // Empty item 3 (price 40) with exact payments.
    for (int i = 0; i < 8; i++) begin
      insert_coin(2'b10);
      insert_coin(2'b01);
      insert_coin(2'b00);
      exp_q.push_back(ev_dispense(2'd3));
      select_item(2'd3);
      wait_idle("vend_item3");
    end
    check_output("sold_out_item3", 32'(bus_if.sold_out), 32'b1000);
    insert_coin(2'b01);
    exp_q.push_back(ev_soldout());
    select_item(2'd3);
    exp_q.push_back(ev_funds());
    select_item(2'd2);
    check_output("bal_after_errors", 32'(bus_if.balance), 10);
    check_output("busy_after_errors", 32'(bus_if.busy), 0);
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3);
    check_output("sold_out_restocked", 32'(bus_if.sold_out), 0);

    // Cancel + select + coin together at 15: coin rejected, refund 10 then 5.
    insert_coin(2'b00);
    check_output("bal_15", 32'(bus_if.balance), 15);
    exp_q.push_back(ev_reject(ev_none()));
    exp_q.push_back(ev_change(2'b01));
    exp_q.push_back(ev_change(2'b00));
    apply_stimulus(1'b1, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0);
    wait_idle("simul_refund");
    check_output("bal_after_simul", 32'(bus_if.balance), 0);

    // Reset between change coins abandons the refund.
    insert_coin(2'b10);
    insert_coin(2'b10);
    exp_q.push_back(ev_change(2'b10));
    apply_stimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    idle_cycle();
    check_output("mid_change_balance", 32'(bus_if.balance), 25);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_balance", 32'(bus_if.balance), 0);
    check_output("async_rst_busy", 32'(bus_if.busy), 0);
    check_output("async_rst_change", 32'(bus_if.change_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) idle_cycle();
    check_output("post_rst_balance", 32'(bus_if.balance), 0);
    check_output("post_rst_busy", 32'(bus_if.busy), 0);
    check_output("post_rst_sold_out", 32'(bus_if.sold_out), 0);

    check_output("events_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
